// File: rtl/alu_div.sv
// Multi-cycle RV64 divide/remainder unit (DIV/DIVU/REM/REMU and W forms), 64-iteration restoring.
// Optional `DIV_FAST_SPECIAL_EN`: divide-by-zero and signed overflow finish directly from IDLE.
module alu_div #(
    parameter int XLEN          = 64,
    parameter int SEL_DIV_WIDTH = 4,
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_DIV   = SEL_DIV_WIDTH'(1),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_DIVU  = SEL_DIV_WIDTH'(2),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_REM   = SEL_DIV_WIDTH'(3),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_REMU  = SEL_DIV_WIDTH'(4),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_DIVW  = SEL_DIV_WIDTH'(5),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_DIVUW = SEL_DIV_WIDTH'(6),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_REMW  = SEL_DIV_WIDTH'(7),
    parameter logic [SEL_DIV_WIDTH-1:0] SEL_REMUW = SEL_DIV_WIDTH'(8)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          a,
    input  logic [XLEN-1:0]          b,
    input  logic [SEL_DIV_WIDTH-1:0] sig,
    input  logic                     stall,
    output logic [XLEN-1:0]          div_c,
    output logic                     stall_this_alu_div
);
    localparam logic RstEnable = 1'b1;
    localparam int   CW        = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] div_c_q, div_c_d;
    logic [XLEN-1:0] dividend_q, dividend_d;  // op-width extended dividend, kept for special results
    logic [XLEN-1:0] divisor_q, divisor_d;    // divisor magnitude
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            rem_op_q, rem_op_d, sgn_q, sgn_d, word_q, word_d;
    logic            sa_q, sa_d, sb_q, sb_d;

    logic            is_div, in_rem, in_sgn, in_word, in_sa, in_sb;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [XLEN:0]   rem_shift, rem_diff;
    logic [XLEN-1:0] quo_next, rem_next;

    function automatic logic is_special(input logic sgn, input logic word, input logic sb,
                                        input logic [XLEN-1:0] dividend,
                                        input logic [XLEN-1:0] divisor);
        logic [XLEN-1:0] min_val;
        min_val = word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
        return (divisor == '0) || (sgn && sb && divisor == XLEN'(1) && dividend == min_val);
    endfunction

    function automatic logic [XLEN-1:0] final_result(
        input logic rem_op, input logic sgn, input logic word, input logic sa, input logic sb,
        input logic [XLEN-1:0] dividend, input logic [XLEN-1:0] divisor,
        input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rmd);
        logic [XLEN-1:0] res;
        if (divisor == '0)
            res = rem_op ? dividend : '1;
        else if (is_special(sgn, word, sb, dividend, divisor))
            res = rem_op ? '0 : dividend;
        else if (rem_op)
            res = sa ? -rmd : rmd;
        else
            res = (sa ^ sb) ? -quo : quo;
        if (word)
            res = {{(XLEN-32){res[31]}}, res[31:0]};
        return res;
    endfunction

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_div  = 1'b1;
        in_rem  = 1'b0;
        in_sgn  = 1'b0;
        in_word = 1'b0;
        case (sig)
            SEL_DIV:   in_sgn = 1'b1;
            SEL_DIVU:  ;
            SEL_REM:   begin in_sgn = 1'b1; in_rem = 1'b1; end
            SEL_REMU:  in_rem = 1'b1;
            SEL_DIVW:  begin in_sgn = 1'b1; in_word = 1'b1; end
            SEL_DIVUW: in_word = 1'b1;
            SEL_REMW:  begin in_sgn = 1'b1; in_rem = 1'b1; in_word = 1'b1; end
            SEL_REMUW: begin in_rem = 1'b1; in_word = 1'b1; end
            default:   is_div = 1'b0;
        endcase
    end

    always_comb begin
        a_ext = a;
        b_ext = b;
        if (in_word) begin
            a_ext = {{(XLEN-32){in_sgn & a[31]}}, a[31:0]};
            b_ext = {{(XLEN-32){in_sgn & b[31]}}, b[31:0]};
        end
        in_sa = in_sgn & a_ext[XLEN-1];
        in_sb = in_sgn & b_ext[XLEN-1];
        a_mag = in_sa ? -a_ext : a_ext;
        b_mag = in_sb ? -b_ext : b_ext;
    end

    // One restoring step; the extra remainder bit keeps divisors above 2^(XLEN-1) exact.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
        quo_next  = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
        rem_next  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        div_c_d    = div_c_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        rem_op_d   = rem_op_q;
        sgn_d      = sgn_q;
        word_d     = word_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        case (state_q)
            IDLE: if (is_div) begin
                dividend_d = a_ext;
                divisor_d  = b_mag;
                quo_d      = a_mag;
                rem_d      = '0;
                rem_op_d   = in_rem;
                sgn_d      = in_sgn;
                word_d     = in_word;
                sa_d       = in_sa;
                sb_d       = in_sb;
                count_d    = '0;
                state_d    = CALC;
`ifdef DIV_FAST_SPECIAL_EN
                if (is_special(in_sgn, in_word, in_sb, a_ext, b_mag)) begin
                    div_c_d = final_result(in_rem, in_sgn, in_word, in_sa, in_sb,
                                           a_ext, b_mag, '0, '0);
                    state_d = DONE;
                end
`endif
            end
            CALC: if (!is_div) begin
                state_d = IDLE;
            end else begin
                quo_d   = quo_next;
                rem_d   = rem_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    div_c_d = final_result(rem_op_q, sgn_q, word_q, sa_q, sb_q,
                                           dividend_q, divisor_q, quo_next, rem_next);
                    state_d = DONE;
                end
            end
            DONE: if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset == RstEnable) begin
            state_q    <= IDLE;
            count_q    <= '0;
            div_c_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            rem_op_q   <= 1'b0;
            sgn_q      <= 1'b0;
            word_q     <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_c_q    <= div_c_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            rem_op_q   <= rem_op_d;
            sgn_q      <= sgn_d;
            word_q     <= word_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
        end
    end

    assign div_c              = div_c_q;
    assign stall_this_alu_div = is_div && (state_q != DONE);

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: vector table through a result scoreboard, plus stall/flush/reset sequences.
// Build with or without `DIV_FAST_SPECIAL_EN` to match the RTL configuration.
module tb_alu_div;
    localparam logic [3:0] NOP = 4'd0, DIV = 4'd1, DIVU = 4'd2, REM = 4'd3, REMU = 4'd4;
    localparam logic [3:0] DIVW = 4'd5, DIVUW = 4'd6, REMW = 4'd7, REMUW = 4'd8;
    localparam int NORMAL_LAT = 65;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 65;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a, b;
    logic [3:0]  sig;
    logic        stall;
    logic [63:0] div_c;
    logic        stall_this_alu_div;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    alu_div dut (
        .clk                (clk),
        .reset              (reset),
        .a                  (a),
        .b                  (b),
        .sig                (sig),
        .stall              (stall),
        .div_c              (div_c),
        .stall_this_alu_div (stall_this_alu_div)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts stall-request cycles (sampled on negedges) until the unit reports DONE.
    task automatic wait_done(input string name, input int swap_at, output int lat);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (stall_this_alu_div) begin
                n++;
                if (n == swap_at) begin
                    a = 64'd7;
                    b = 64'd3;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) check({name, "_timeout"}, 64'(stall_this_alu_div), 64'd0);
        lat = n;
    endtask

    task automatic check_result(input string name);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, div_c, ~div_c);
        end else begin
            exp = sb_q.pop_front();
            check(name, div_c, exp);
            last_exp = exp;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] aa,
                          input logic [63:0] bb, input logic [63:0] exp, input int exp_lat,
                          input int swap_at);
        int lat;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        sig = op;
        a   = aa;
        b   = bb;
        wait_done(name, swap_at, lat);
        check_result(name);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        sig = NOP;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        sig   = NOP;
        a     = '0;
        b     = '0;
        stall = 1'b0;
        last_exp = '0;

        vecs.push_back('{DIVU,  64'd100, 64'd7, 64'd14, 1'b0});
        vecs.push_back('{REMU,  64'd100, 64'd7, 64'd2, 1'b0});
        vecs.push_back('{DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back('{REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0});
        vecs.push_back('{DIVW,  64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back('{DIV,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back('{REM,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0});
        vecs.push_back('{DIVU,  ONES, 64'h8000_0000_0000_0001, 64'd1, 1'b0});
        vecs.push_back('{REMU,  ONES, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{REMW,  64'h0000_0000_FFFF_FFF9, 64'd3, ONES, 1'b0});
        vecs.push_back('{DIVUW, 64'h1_FFFF_FFFE, 64'd2, 64'h7FFF_FFFF, 1'b0});
        vecs.push_back('{REMUW, 64'hFFFF_FFFF, 64'h10, 64'hF, 1'b0});
        vecs.push_back('{DIVUW, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0});
        vecs.push_back('{DIVW,  64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0});
        vecs.push_back('{REMW,  64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b0});
        vecs.push_back('{DIVU,  64'd0, 64'd5, 64'd0, 1'b0});
        vecs.push_back('{DIV,   64'd5, 64'd0, ONES, 1'b1});
        vecs.push_back('{REM,   64'd5, 64'd0, 64'd5, 1'b1});
        vecs.push_back('{DIVUW, 64'h1_0000_0005, 64'd0, ONES, 1'b1});
        vecs.push_back('{REMUW, 64'h2_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1'b1});
        vecs.push_back('{DIVW,  64'd7, 64'h1_0000_0000, ONES, 1'b1});
        vecs.push_back('{DIV,   64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1'b1});
        vecs.push_back('{REM,   64'h8000_0000_0000_0000, ONES, 64'd0, 1'b1});
        vecs.push_back('{DIVW,  64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1'b1});
        vecs.push_back('{REMW,  64'h8000_0000, ONES, 64'd0, 1'b1});

        // Reset state and the combinational stall request in IDLE.
        #2;
        check("rst_div_c", div_c, 64'd0);
        check("rst_stall_nop", 64'(stall_this_alu_div), 64'd0);
        sig = DIV;
        #1;
        check("idle_stall_req", 64'(stall_this_alu_div), 64'd1);
        sig = NOP;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].special ? SPECIAL_LAT : NORMAL_LAT, -1);

        // Operands changed mid-calculation must not disturb the latched op.
        run_op("latched_ops", DIVU, 64'd1000, 64'd10, 64'd100, NORMAL_LAT, 5);

        // Global stall held at DONE with the op still presented.
        sb_q.push_back(64'd5);
        @(posedge clk);
        #1;
        sig   = DIV;
        a     = 64'd20;
        b     = 64'd4;
        stall = 1'b1;
        wait_done("hold", -1, lat);
        check_result("hold");
        check("hold_lat", 64'(lat), 64'(NORMAL_LAT));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_req%0d", i), 64'(stall_this_alu_div), 64'd0);
            check($sformatf("hold_val%0d", i), div_c, 64'd5);
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        check("release_idle", 64'(stall_this_alu_div), 64'd1);
        sig = NOP;
        check("release_val", div_c, 64'd5);

        // Flush in CALC: back to IDLE, result register untouched.
        @(posedge clk);
        #1;
        sig = DIVU;
        a   = 64'd50;
        b   = 64'd5;
        repeat (10) @(negedge clk);
        sig = NOP;
        repeat (80) @(negedge clk);
        check("flush_val", div_c, last_exp);

        // Asynchronous reset in the middle of a calculation (count == 30).
        @(posedge clk);
        #1;
        sig = DIVU;
        a   = 64'd1000;
        b   = 64'd10;
        repeat (31) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_div_c", div_c, 64'd0);
        sig = NOP;
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", DIVU, 64'd9, 64'd3, 64'd3, NORMAL_LAT, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
